// File: rtl/lsu_bus_bridge_if.sv
// Bundle of every handshake and bus signal around the LSU bus bridge.
//   req_*  : memory-stage request (valid/ready, store flag, address, data, size, unsigned)
//   resp_* : response back to the memory stage (valid/ready, extended load data, error)
//   ar/r   : AXI4-Lite-style read address and read data channels
//   aw/w/b : AXI4-Lite-style write address, write data and write response channels
// Modport master is the bridge's view; modport slave is the environment's view
// (memory stage plus data memory).
interface lsu_bus_bridge_if #(
  parameter int unsigned ADDR_W = 64
) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_wen;
  logic [ADDR_W-1:0] req_addr;
  logic [63:0]       req_wdata;
  logic [3:0]        req_dwhb;
  logic              req_unsigned;

  logic              resp_valid;
  logic              resp_ready;
  logic [63:0]       resp_rdata;
  logic              resp_err;

  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [63:0]       rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [63:0]       wdata;
  logic [7:0]        wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  modport master (
    input  req_valid, req_wen, req_addr, req_wdata, req_dwhb, req_unsigned,
    output req_ready,
    output resp_valid, resp_rdata, resp_err,
    input  resp_ready,
    output araddr, arvalid, rready,
    input  arready, rdata, rresp, rvalid,
    output awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  awready, wready, bresp, bvalid
  );

  modport slave (
    output req_valid, req_wen, req_addr, req_wdata, req_dwhb, req_unsigned,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_err,
    output resp_ready,
    input  araddr, arvalid, rready,
    output arready, rdata, rresp, rvalid,
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/lsu_bus_bridge.sv
// Load/store bus bridge: takes one load or store at a time from the memory stage,
// issues it as an 8-byte-aligned AXI4-Lite-style read or write, and returns the
// lane-extracted, sign/zero-extended load data or the store completion.
// Misaligned accesses and non-one-hot sizes are answered with an error without
// touching the bus; nonzero rresp/bresp are also reported as errors.
// Ports:
//   i_clk   : clock, rising edge
//   i_rst_n : asynchronous active-low reset
//   io_bus  : lsu_bus_bridge_if.master carrying request, response and bus channels
module lsu_bus_bridge #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
) (
  input logic              i_clk,
  input logic              i_rst_n,
  lsu_bus_bridge_if.master io_bus
);

  typedef enum logic [2:0] {StIdle, StAr, StR, StAwW, StB, StRsp} state_e;

  state_e              r_state, w_state_d;
  logic [ADDR_W-1:0]   r_addr, w_addr_d;
  logic [2:0]          r_sh, w_sh_d;
  logic [3:0]          r_size, w_size_d;
  logic                r_uns, w_uns_d;
  logic [DATA_W-1:0]   r_wdata, w_wdata_d;
  logic [DATA_W/8-1:0] r_wstrb, w_wstrb_d;
  logic                r_awvalid, w_awvalid_d;
  logic                r_wvalid, w_wvalid_d;
  logic [DATA_W-1:0]   r_rdata, w_rdata_d;
  logic                r_err, w_err_d;

  logic              w_onehot, w_misalign;
  logic [7:0]        w_size_mask;
  logic [63:0]       w_rshift, w_ldata;

  // Request decode, evaluated against the live request while idle.
  assign w_onehot   = (io_bus.req_dwhb != 4'b0) &&
                      ((io_bus.req_dwhb & (io_bus.req_dwhb - 4'd1)) == 4'b0);
  assign w_misalign = (io_bus.req_dwhb[3] && (io_bus.req_addr[2:0] != 3'b0)) ||
                      (io_bus.req_dwhb[2] && (io_bus.req_addr[1:0] != 2'b0)) ||
                      (io_bus.req_dwhb[1] && io_bus.req_addr[0]);

  always_comb begin
    if (io_bus.req_dwhb[3])      w_size_mask = 8'hFF;
    else if (io_bus.req_dwhb[2]) w_size_mask = 8'h0F;
    else if (io_bus.req_dwhb[1]) w_size_mask = 8'h03;
    else                         w_size_mask = 8'h01;
  end

  // Load lane extraction uses the captured shift/size, so the raw bus word can
  // be consumed directly in the rvalid cycle.
  assign w_rshift = io_bus.rdata >> {r_sh, 3'b000};

  always_comb begin
    w_ldata = w_rshift;
    if (r_size[0]) begin
      w_ldata = r_uns ? {56'b0, w_rshift[7:0]} : {{56{w_rshift[7]}}, w_rshift[7:0]};
    end else if (r_size[1]) begin
      w_ldata = r_uns ? {48'b0, w_rshift[15:0]} : {{48{w_rshift[15]}}, w_rshift[15:0]};
    end else if (r_size[2]) begin
      w_ldata = r_uns ? {32'b0, w_rshift[31:0]} : {{32{w_rshift[31]}}, w_rshift[31:0]};
    end
  end

  always_comb begin
    w_state_d   = r_state;
    w_addr_d    = r_addr;
    w_sh_d      = r_sh;
    w_size_d    = r_size;
    w_uns_d     = r_uns;
    w_wdata_d   = r_wdata;
    w_wstrb_d   = r_wstrb;
    w_awvalid_d = r_awvalid;
    w_wvalid_d  = r_wvalid;
    w_rdata_d   = r_rdata;
    w_err_d     = r_err;
    unique case (r_state)
      StIdle: begin
        if (io_bus.req_valid) begin
          w_addr_d = {io_bus.req_addr[ADDR_W-1:3], 3'b000};
          w_sh_d   = io_bus.req_addr[2:0];
          w_size_d = io_bus.req_dwhb;
          w_uns_d  = io_bus.req_unsigned;
          if (!w_onehot || w_misalign) begin
            w_err_d   = 1'b1;
            w_rdata_d = '0;
            w_state_d = StRsp;
          end else if (io_bus.req_wen) begin
            w_wdata_d   = io_bus.req_wdata << {io_bus.req_addr[2:0], 3'b000};
            w_wstrb_d   = w_size_mask << io_bus.req_addr[2:0];
            w_awvalid_d = 1'b1;
            w_wvalid_d  = 1'b1;
            w_state_d   = StAwW;
          end else begin
            w_state_d = StAr;
          end
        end
      end
      StAr: begin
        if (io_bus.arready) w_state_d = StR;
      end
      StR: begin
        if (io_bus.rvalid) begin
          w_err_d   = (io_bus.rresp != 2'b00);
          w_rdata_d = (io_bus.rresp != 2'b00) ? '0 : w_ldata;
          w_state_d = StRsp;
        end
      end
      StAwW: begin
        // AW and W complete independently; leave once neither is still pending.
        if (r_awvalid && io_bus.awready) w_awvalid_d = 1'b0;
        if (r_wvalid && io_bus.wready)   w_wvalid_d  = 1'b0;
        if (!w_awvalid_d && !w_wvalid_d) w_state_d   = StB;
      end
      StB: begin
        if (io_bus.bvalid) begin
          w_err_d   = (io_bus.bresp != 2'b00);
          w_rdata_d = '0;
          w_state_d = StRsp;
        end
      end
      StRsp: begin
        if (io_bus.resp_ready) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= StIdle;
      r_addr    <= '0;
      r_sh      <= '0;
      r_size    <= '0;
      r_uns     <= 1'b0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_addr    <= w_addr_d;
      r_sh      <= w_sh_d;
      r_size    <= w_size_d;
      r_uns     <= w_uns_d;
      r_wdata   <= w_wdata_d;
      r_wstrb   <= w_wstrb_d;
      r_awvalid <= w_awvalid_d;
      r_wvalid  <= w_wvalid_d;
      r_rdata   <= w_rdata_d;
      r_err     <= w_err_d;
    end
  end

  // All outputs come from the state register or data registers only.
  assign io_bus.req_ready  = (r_state == StIdle);
  assign io_bus.arvalid    = (r_state == StAr);
  assign io_bus.rready     = (r_state == StR);
  assign io_bus.bready     = (r_state == StB);
  assign io_bus.resp_valid = (r_state == StRsp);
  assign io_bus.araddr     = r_addr;
  assign io_bus.awaddr     = r_addr;
  assign io_bus.awvalid    = r_awvalid;
  assign io_bus.wvalid     = r_wvalid;
  assign io_bus.wdata      = r_wdata;
  assign io_bus.wstrb      = r_wstrb;
  assign io_bus.resp_rdata = r_rdata;
  assign io_bus.resp_err   = r_err;

endmodule
